vmem_banked_lsu: RTL and testbench
==================================

Name: vmem_banked_lsu

Overview:
- Parametrised banked vector load/store unit; successor to the fixed 16-bank, unit-stride-only data memory in the CPU top.
- Sits between the vector register file (256-bit lane bundles) and NUM_BANKS word-wide memory banks.
- Generalises lane count, bank count and data width, and adds:
  - strided access;
  - per-lane masking;
  - bank-conflict serialisation.
- Fixed request/response handshake with backpressure.

Parameters:
- LANES, 16, elements per vector access.
- NUM_BANKS, 16, bank count; power of 2, ≥ 2.
- DATA_W, 16, element width in bits.
- ADDR_W, 16, byte-address width; bit 0 ignored, so word address = addr[ADDR_W-1:1].
- STRIDE_W, 8, signed element stride width, in words.
- BANK_DEPTH, 2**(ADDR_W-1)/NUM_BANKS, words per bank.

Ports:
- clk  in  1  clock, all state updates on posedge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_base  in  ADDR_W  byte address of lane 0.
- req_stride  in  STRIDE_W  signed word stride between lanes.
- req_mask  in  LANES  lane enables.
- req_wdata  in  LANES*DATA_W  store data; lane i at bits [i*DATA_W +: DATA_W].
- resp_valid  out  1  access complete.
- resp_ready  in  1  consumer accepts response.
- resp_we  out  1  echoes req_we of the completed request.
- resp_rdata  out  LANES*DATA_W  load data; same lane packing as req_wdata.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE;
  - req_ready = 1, resp_valid = 0, resp_we = 0, resp_rdata = 0, busy = 0;
  - pending mask cleared.
  - Bank arrays are NOT reset.
  - Reset mid-operation abandons the access. Any store lanes already issued remain written; unissued lanes are dropped.
- Request acceptance:
  - A request is accepted on a posedge with req_valid && req_ready.
  - req_ready = 1 only in IDLE.
  - On accept: latch all request fields; pending = req_mask; clear resp_rdata; go to ISSUE.
- Lane addressing:
  - waddr_i = req_base[ADDR_W-1:1] + i*sext(req_stride), computed modulo 2**(ADDR_W-1) (wrap-around, no error).
  - bank_i = waddr_i mod NUM_BANKS.
  - row_i = waddr_i / NUM_BANKS.
- ISSUE, one cycle per round:
  - For each bank, select the lowest-index pending lane mapping to it. That is at most one op per bank per cycle.
  - Selected lanes clear their pending bit.
  - Stores write req_wdata lane to bank[row] at the edge.
  - Loads read synchronously; data is valid 1 cycle later and written into resp_rdata lane i.
- ISSUE exit, when pending becomes 0 after a round:
  - load → DRAIN;
  - store → RESP.
- DRAIN: 1 cycle to capture the final read data, then → RESP.
- RESP:
  - resp_valid = 1; resp_rdata and resp_we held stable until resp_ready.
  - On resp_valid && resp_ready → IDLE.
  - In this same cycle, req_ready remains 0; a new request is accepted from the next cycle.
- Timing:
  - Load, conflict-free: resp_valid rises 2 edges after the accept edge.
  - Store, conflict-free: resp_valid rises 1 edge after the accept edge.
  - Each extra conflict round (max lanes sharing one bank, minus 1) adds 1 cycle.
- Masking: masked-off lanes are never issued and read back as 0.
- Empty mask: ISSUE performs no bank ops; exits immediately. Load returns all-zero data after the same 2-edge latency.
- Stride 0: all lanes hit one bank; LANES rounds.
- Duplicate store addresses: lanes issue in ascending index order, so the highest-index enabled lane's data persists.
- Lane-to-bank distinctness: stride s with gcd(s, NUM_BANKS) = 1 and LANES ≤ NUM_BANKS ⇒ all lanes land in distinct banks ⇒ single round.

Decomposition:
- Package vmem_pkg holds:
  - the state enum (IDLE, ISSUE, DRAIN, RESP);
  - default LANES/NUM_BANKS/DATA_W constants;
  - a function computing lane word address from base/stride/index.
- Sub-module vmem_bank: one synchronous single-port RAM per bank (DATA_W × BANK_DEPTH, 1-cycle read, write-enable).
  - Instantiated NUM_BANKS times by generate loop.
- The conflict picker stays in the top.

Test Plan:
- Unit-stride store, then load:
  - store: base 0x0000, stride 1, mask 0xFFFF, lane i data = 0x1000+i → resp_valid 1 edge after accept.
  - load: same addresses → resp_rdata lane i = 0x1000+i, 2 edges after accept, single issue round.
- Stride 2 load over the same region: base 0x0000 → lane i = word 2i; bank conflicts give 2 rounds; resp_valid at 3 edges; lanes 0-7 = 0x1000,0x1002,…,0x100E.
- Stride 0 store:
  - base 0x0040, mask 0x0005, lane0 data 0xAAAA, lane2 data 0xBBBB → 2 rounds.
  - load word 0x20 → 0xBBBB.
  - load lanes with mask 0x0000 → all-zero data, latency 2.
- Wrap and negative stride: load at base 0xFFFE, stride -1 (0xFF), after storing lane i data = 0x2000+i at those addresses → lane i reads word 0x7FFF-i, correct data, no hang.
- Backpressure and reset:
  - hold resp_ready=0 for 5 cycles → resp_valid and resp_rdata stable, req_ready 0.
  - assert rst_n low mid-ISSUE of a stride-0 access → next cycle req_ready=1, resp_valid=0, busy=0.

Source files
------------

// File: rtl/vmem_pkg.sv
// Shared types and helpers for the banked vector load/store unit.
package vmem_pkg;

  localparam int VMEM_LANES     = 16;
  localparam int VMEM_NUM_BANKS = 16;
  localparam int VMEM_DATA_W    = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    RESP  = 2'd3
  } vmem_state_e;

  // Word address of lane idx: base + idx*stride, in 32-bit two's complement.
  // The caller truncates to its word-address width, which gives the
  // modulo-2**(ADDR_W-1) wrap-around.
  function automatic logic [31:0] lane_waddr(input logic [31:0]        base_w,
                                             input logic signed [31:0] stride_w,
                                             input int                 idx);
    logic signed [31:0] off;
    off = idx * stride_w;
    return base_w + off;
  endfunction

endpackage

// File: rtl/vmem_bank.sv
// One word-wide synchronous single-port RAM bank with a 1-cycle read.
module vmem_bank #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 2048,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              en_i,
  input  logic              we_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Write on enabled store, register read data on enabled load.
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) mem[addr_i] <= wdata_i;
      else      rdata_q     <= mem[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/vmem_banked_lsu.sv
// Banked vector load/store unit: strided, masked lane accesses spread over
// NUM_BANKS RAMs, serialising lanes that collide on a bank.
module vmem_banked_lsu
  import vmem_pkg::*;
#(
  parameter int LANES      = VMEM_LANES,
  parameter int NUM_BANKS  = VMEM_NUM_BANKS,
  parameter int DATA_W     = VMEM_DATA_W,
  parameter int ADDR_W     = 16,
  parameter int STRIDE_W   = 8,
  parameter int BANK_DEPTH = 2 ** (ADDR_W - 1) / NUM_BANKS
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_we,
  input  logic [ADDR_W-1:0]         req_base,
  input  logic [STRIDE_W-1:0]       req_stride,
  input  logic [LANES-1:0]          req_mask,
  input  logic [LANES*DATA_W-1:0]   req_wdata,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic                      resp_we,
  output logic [LANES*DATA_W-1:0]   resp_rdata,
  output logic                      busy
);

  localparam int WA_W   = ADDR_W - 1;
  localparam int BANK_W = $clog2(NUM_BANKS);
  localparam int ROW_W  = (BANK_DEPTH > 1) ? $clog2(BANK_DEPTH) : 1;
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

  vmem_state_e state_q, state_d;
  logic [LANES-1:0]        pending_q, pending_d;
  logic                    we_q;
  logic [LANES*DATA_W-1:0] rdata_q, rdata_d;
  logic [NUM_BANKS-1:0]    rd_vld_q, rd_vld_d;

  logic [WA_W-1:0]              base_q;
  logic signed [STRIDE_W-1:0]   stride_q;
  logic [LANES*DATA_W-1:0]      wdata_q;
  logic [LANE_W-1:0]            rd_lane_q [NUM_BANKS];

  logic [WA_W-1:0]   lane_wa   [LANES];
  logic [BANK_W-1:0] lane_bank [LANES];
  logic [ROW_W-1:0]  lane_row  [LANES];

  logic [NUM_BANKS-1:0] sel_vld;
  logic [LANE_W-1:0]    sel_lane [NUM_BANKS];
  logic [LANES-1:0]     issued;

  logic [NUM_BANKS-1:0] bank_en;
  logic [ROW_W-1:0]     bank_row   [NUM_BANKS];
  logic [DATA_W-1:0]    bank_wdata [NUM_BANKS];
  logic [DATA_W-1:0]    bank_dout  [NUM_BANKS];

  logic accept;
  assign accept = (state_q == IDLE) && req_valid;

  // Per-lane word address split into bank index and row within the bank.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      lane_wa[i]   = WA_W'(lane_waddr(32'(base_q), 32'(stride_q), i));
      lane_bank[i] = BANK_W'(lane_wa[i]);
      lane_row[i]  = ROW_W'(lane_wa[i] >> BANK_W);
    end
  end

  // Conflict picker: each bank takes its lowest-index pending lane.
  always_comb begin
    issued = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      sel_vld[b]  = 1'b0;
      sel_lane[b] = '0;
      for (int i = 0; i < LANES; i++) begin
        if (!sel_vld[b] && pending_q[i] && (lane_bank[i] == BANK_W'(b))) begin
          sel_vld[b]  = 1'b1;
          sel_lane[b] = LANE_W'(i);
        end
      end
      if (sel_vld[b]) issued[sel_lane[b]] = 1'b1;
    end
  end

  // Bank port drive for the lanes chosen this round.
  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      bank_en[b]    = (state_q == ISSUE) && sel_vld[b];
      bank_row[b]   = lane_row[sel_lane[b]];
      bank_wdata[b] = wdata_q[sel_lane[b]*DATA_W +: DATA_W];
    end
  end

  for (genvar gb = 0; gb < NUM_BANKS; gb++) begin : g_bank
    vmem_bank #(
      .DATA_W (DATA_W),
      .DEPTH  (BANK_DEPTH),
      .AW     (ROW_W)
    ) u_bank (
      .clk_i   (clk),
      .en_i    (bank_en[gb]),
      .we_i    (we_q),
      .addr_i  (bank_row[gb]),
      .wdata_i (bank_wdata[gb]),
      .rdata_o (bank_dout[gb])
    );
  end

  // Next state, pending lanes and load-capture bookkeeping.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    rd_vld_d  = '0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d   = ISSUE;
          pending_d = req_mask;
        end
      end
      ISSUE: begin
        pending_d = pending_q & ~issued;
        if (!we_q) rd_vld_d = sel_vld;
        if (pending_d == '0) state_d = we_q ? RESP : DRAIN;
      end
      DRAIN: state_d = RESP;
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Read data from the previous round lands in its lane; accept clears all.
  always_comb begin
    rdata_d = rdata_q;
    if (accept) begin
      rdata_d = '0;
    end else begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        if (rd_vld_q[b]) rdata_d[rd_lane_q[b]*DATA_W +: DATA_W] = bank_dout[b];
      end
    end
  end

  // Control and response state, cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
      we_q      <= 1'b0;
      rdata_q   <= '0;
      rd_vld_q  <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      rdata_q   <= rdata_d;
      rd_vld_q  <= rd_vld_d;
      if (accept) we_q <= req_we;
    end
  end

  // Request payload and read-lane tags; not reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      base_q   <= req_base[ADDR_W-1:1];
      stride_q <= req_stride;
      wdata_q  <= req_wdata;
    end
    rd_lane_q <= sel_lane;
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign busy       = (state_q != IDLE);
  assign resp_we    = we_q;
  assign resp_rdata = rdata_q;

endmodule

// File: tb/tb_vmem_banked_lsu.sv
// Randomised and directed bench for vmem_banked_lsu with a flat-memory model.
module tb_vmem_banked_lsu;

  localparam int LANES = 16;
  localparam int NB    = 16;
  localparam int DW    = 16;
  localparam int WORDS = 32768;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                req_valid = 1'b0;
  logic                req_ready;
  logic                req_we = 1'b0;
  logic [15:0]         req_base = '0;
  logic [7:0]          req_stride = '0;
  logic [LANES-1:0]    req_mask = '0;
  logic [LANES*DW-1:0] req_wdata = '0;
  logic                resp_valid;
  logic                resp_ready = 1'b0;
  logic                resp_we;
  logic [LANES*DW-1:0] resp_rdata;
  logic                busy;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [15:0] mem_m [WORDS];
  bit          written [WORDS];

  vmem_banked_lsu dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_base   (req_base),
    .req_stride (req_stride),
    .req_mask   (req_mask),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_we    (resp_we),
    .resp_rdata (resp_rdata),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Model: word address of a lane from the byte base and signed word stride.
  function automatic int model_wa(input logic [15:0] base, input logic [7:0] stride, input int i);
    int s;
    s = (stride > 127) ? int'(stride) - 256 : int'(stride);
    return ((int'(base) / 2) + i * s) & (WORDS - 1);
  endfunction

  // Model: rounds = worst-case number of enabled lanes sharing one bank, at least 1.
  function automatic int model_rounds(input logic [15:0] base, input logic [7:0] stride,
                                      input logic [LANES-1:0] mask);
    int cnt [NB];
    int mx;
    mx = 1;
    for (int b = 0; b < NB; b++) cnt[b] = 0;
    for (int i = 0; i < LANES; i++)
      if (mask[i]) cnt[model_wa(base, stride, i) % NB]++;
    for (int b = 0; b < NB; b++) if (cnt[b] > mx) mx = cnt[b];
    return mx;
  endfunction

  // One full transaction: drive, measure latency, check response, optionally
  // stall the consumer for 'hold' cycles, then consume.
  task automatic access(input string tag, input bit we, input logic [15:0] base,
                        input logic [7:0] stride, input logic [LANES-1:0] mask,
                        input logic [255:0] wdata, input int hold);
    logic [255:0] exp_rd;
    logic [255:0] held;
    int exp_lat, lat, wa;
    exp_rd  = '0;
    exp_lat = model_rounds(base, stride, mask) + (we ? 0 : 1);
    for (int i = 0; i < LANES; i++) begin
      if (mask[i]) begin
        wa = model_wa(base, stride, i);
        if (we) begin
          mem_m[wa]   = wdata[i*DW +: DW];
          written[wa] = 1'b1;
        end else begin
          exp_rd[i*DW +: DW] = mem_m[wa];
        end
      end
    end
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_base = base; req_stride = stride;
    req_mask = mask; req_wdata = wdata;
    chk({tag, ".req_ready"}, 256'(req_ready), 256'(1));
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    while (!resp_valid && lat < 100) begin
      @(posedge clk);
      #1 lat++;
    end
    chk({tag, ".latency"}, 256'(lat), 256'(exp_lat));
    chk({tag, ".resp_we"}, 256'(resp_we), 256'(we));
    chk({tag, ".rdata"}, resp_rdata, exp_rd);
    held = resp_rdata;
    for (int k = 0; k < hold; k++) begin
      @(posedge clk);
      #1;
      chk({tag, ".hold_valid"}, 256'(resp_valid), 256'(1));
      chk({tag, ".hold_rdata"}, resp_rdata, held);
      chk({tag, ".hold_req_ready"}, 256'(req_ready), 256'(0));
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    chk({tag, ".idle_ready"}, 256'(req_ready), 256'(1));
    chk({tag, ".idle_valid"}, 256'(resp_valid), 256'(0));
  endtask

  initial begin
    logic [255:0] wd;
    logic [15:0]  rb;
    logic [7:0]   rs;
    logic [15:0]  rm;
    int wa;

    for (int w = 0; w < WORDS; w++) begin
      mem_m[w] = '0; written[w] = 1'b0;
    end

    // Reset state
    #12;
    chk("rst.req_ready", 256'(req_ready), 256'(1));
    chk("rst.resp_valid", 256'(resp_valid), 256'(0));
    chk("rst.busy", 256'(busy), 256'(0));
    chk("rst.resp_we", 256'(resp_we), 256'(0));
    chk("rst.resp_rdata", resp_rdata, 256'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Unit-stride store then load
    for (int i = 0; i < LANES; i++) wd[i*DW +: DW] = 16'h1000 + 16'(i);
    access("st_unit", 1'b1, 16'h0000, 8'd1, 16'hFFFF, wd, 0);
    access("ld_unit", 1'b0, 16'h0000, 8'd1, 16'hFFFF, '0, 0);

    // Stride 2: two lanes per even bank
    access("ld_str2", 1'b0, 16'h0000, 8'd2, 16'hFFFF, '0, 0);

    // Stride 0 store of two lanes to one word; last enabled lane wins
    wd = '0;
    wd[0*DW +: DW] = 16'hAAAA;
    wd[2*DW +: DW] = 16'hBBBB;
    access("st_str0", 1'b1, 16'h0040, 8'd0, 16'h0005, wd, 0);
    access("ld_w20", 1'b0, 16'h0040, 8'd1, 16'h0001, '0, 0);
    access("ld_empty", 1'b0, 16'h0040, 8'd1, 16'h0000, '0, 0);

    // Wrap-around with negative stride
    for (int i = 0; i < LANES; i++) wd[i*DW +: DW] = 16'h2000 + 16'(i);
    access("st_wrap", 1'b1, 16'hFFFE, 8'hFF, 16'hFFFF, wd, 0);
    access("ld_wrap", 1'b0, 16'hFFFE, 8'hFF, 16'hFFFF, '0, 0);

    // Consumer backpressure
    access("ld_bp", 1'b0, 16'h0000, 8'd3, 16'hFFFF, '0, 5);

    // Reset in the middle of a 16-round stride-0 store
    for (int i = 0; i < LANES; i++) wd[i*DW +: DW] = 16'h3000 + 16'(i);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_base = 16'h0200; req_stride = 8'd0;
    req_mask = 16'hFFFF; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst.req_ready", 256'(req_ready), 256'(1));
    chk("midrst.resp_valid", 256'(resp_valid), 256'(0));
    chk("midrst.busy", 256'(busy), 256'(0));
    chk("midrst.resp_rdata", resp_rdata, 256'(0));
    @(negedge clk);
    rst_n = 1'b1;
    mem_m[16'h0100] = 16'h3002;
    written[16'h0100] = 1'b1;
    access("ld_after_rst", 1'b0, 16'h0200, 8'd0, 16'h0001, '0, 0);

    // Randomised store/load pairs against the flat-memory model
    for (int n = 0; n < 24; n++) begin
      for (int i = 0; i < LANES; i++) wd[i*DW +: DW] = 16'($urandom);
      rb = 16'($urandom);
      rs = 8'($urandom);
      rm = 16'($urandom);
      access("rnd_st", 1'b1, rb, rs, rm, wd, 0);
      rb = 16'($urandom);
      if (n % 2 == 0) rb = {rb[15:6], 6'h0} | 16'h0010;
      rs = 8'($urandom_range(0, 5));
      rm = 16'($urandom);
      for (int i = 0; i < LANES; i++) begin
        wa = model_wa(rb, rs, i);
        if (!written[wa]) rm[i] = 1'b0;
      end
      access("rnd_ld", 1'b0, rb, rs, rm, '0, int'($urandom_range(0, 2)));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
